// File: rtl/digit_serial_adder_if.sv
// +----------------------------------------------------------------------------+
// | Module  : digit_serial_adder_if                                            |
// | Brief   : Operand/result handshake bundle for digit_serial_adder.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface digit_serial_adder_if #(
   parameter int N = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         sub;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] sum;
   logic         cout;
   logic         overflow;

   modport master (
      output in_valid, a, b, sub, cin, out_ready,
      input  in_ready, out_valid, sum, cout, overflow
   );

   modport slave (
      input  in_valid, a, b, sub, cin, out_ready,
      output in_ready, out_valid, sum, cout, overflow
   );
endinterface

`default_nettype wire

// File: rtl/digit_serial_adder.sv
// +----------------------------------------------------------------------------+
// | Module  : digit_serial_adder                                               |
// | Brief   : N-bit add/sub, W bits per cycle through a prefix-carry slice.    |
// |           Macro DIGIT_SERIAL_ADDER_OVERFLOW_EN enables signed overflow.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module digit_serial_adder #(
   parameter int N = 32,
   parameter int W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   digit_serial_adder_if.slave bus
);

   localparam int c_D  = N / W;
   localparam int c_KW = (c_D > 1) ? $clog2(c_D) : 1;
   localparam int c_LV = $clog2(W + 1);
   localparam logic [c_KW-1:0] c_KLAST = c_KW'(c_D - 1);

   if ((W < 1) || ((N % W) != 0)) begin : g_bad_width
      $error("digit_serial_adder: N must be a positive multiple of W");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            w_in_ready;
   logic            w_out_valid;
   logic            w_accept;
   logic            w_last;

   logic [N-1:0]    r_a;
   logic [N-1:0]    r_b;
   logic            r_carry;
   logic [c_KW-1:0] r_k;
   logic [N-1:0]    r_sum;
   logic            r_cout;

   logic [W-1:0]    w_ad;
   logic [W-1:0]    w_bd;
   logic [W:0]      w_g0;
   logic [W:0]      w_p0;
   logic [W:0]      w_c;
   logic [W-1:0]    w_sumd;
   logic [N-1:0]    w_a_next;
   logic [N-1:0]    w_b_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_accept = w_in_ready & bus.in_valid;
   assign w_last   = (r_k == c_KLAST);

   // Position 0 of the g/p vectors carries the registered digit carry-in.
   assign w_ad = r_a[W-1:0];
   assign w_bd = r_b[W-1:0];
   assign w_g0 = {w_ad & w_bd, r_carry};
   assign w_p0 = {w_ad ^ w_bd, 1'b0};

   for (genvar lv = 0; lv < c_LV; lv++) begin : g_lvl
      logic [W:0] w_gi;
      logic [W:0] w_pi;
      logic [W:0] w_go;
      logic [W:0] w_po;
      if (lv == 0) begin : g_first
         assign w_gi = w_g0;
         assign w_pi = w_p0;
      end else begin : g_next
         assign w_gi = g_lvl[lv-1].w_go;
         assign w_pi = g_lvl[lv-1].w_po;
      end
      for (genvar i = 0; i <= W; i++) begin : g_bit
         if (i >= (1 << lv)) begin : g_op
            assign w_go[i] = w_gi[i] | (w_pi[i] & w_gi[i-(1<<lv)]);
            assign w_po[i] = w_pi[i] & w_pi[i-(1<<lv)];
         end else begin : g_pass
            assign w_go[i] = w_gi[i];
            assign w_po[i] = w_pi[i];
         end
      end
   end

   logic w_unused_p;
   assign w_unused_p = ^g_lvl[c_LV-1].w_po;

   assign w_c    = g_lvl[c_LV-1].w_go;
   assign w_sumd = w_p0[W:1] ^ w_c[W-1:0];

   // Sum digits shift into the top of r_a as operand digits leave the bottom,
   // so after the last digit r_a's next value is the complete result.
   if (c_D == 1) begin : g_single
      assign w_a_next = w_sumd;
      assign w_b_next = '0;
   end else begin : g_multi
      assign w_a_next = {w_sumd, r_a[N-1:W]};
      assign w_b_next = {{W{1'b0}}, r_b[N-1:W]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_k     <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else if (w_accept) begin
         r_a     <= bus.a;
         r_b     <= bus.sub ? ~bus.b : bus.b;
         r_carry <= bus.cin ^ bus.sub;
         r_k     <= '0;
      end else if (r_state == S_RUN) begin
         r_a     <= w_a_next;
         r_b     <= w_b_next;
         r_carry <= w_c[W];
         if (w_last) begin
            r_sum  <= w_a_next;
            r_cout <= w_c[W];
         end else begin
            r_k    <= r_k + 1'b1;
         end
      end
   end

`ifdef DIGIT_SERIAL_ADDER_OVERFLOW_EN
   logic r_c_msb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_c_msb <= 1'b0;
      end else if ((r_state == S_RUN) && w_last) begin
         r_c_msb <= w_c[W-1];
      end
   end

   assign bus.overflow = r_c_msb ^ r_cout;
`else
   assign bus.overflow = 1'b0;
`endif

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.sum       = r_sum;
   assign bus.cout      = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_digit_serial_adder                                            |
// | Brief   : Directed and reference-model checks of digit_serial_adder.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_digit_serial_adder;

`ifdef DIGIT_SERIAL_ADDER_OVERFLOW_EN
   localparam bit c_OVF_EN = 1'b1;
`else
   localparam bit c_OVF_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          total = 0;
   int          bad = 0;

   logic [31:0] t_a = '0;
   logic [31:0] t_b = '0;
   logic        t_sub = 1'b0;
   logic        t_cin = 1'b0;
   logic [3:0]  t_iv = '0;
   logic [3:0]  t_or = '0;

   logic [31:0] m_sum [4];
   logic [3:0]  m_ird;
   logic [3:0]  m_ovld;
   logic [3:0]  m_cout;
   logic [3:0]  m_ovf;

   always #5 clk = ~clk;

   digit_serial_adder_if #(.N(32)) dif [4] ();

   // Instances 0..3 use W = 8, 32, 4, 1.
   for (genvar i = 0; i < 4; i++) begin : g_dut
      localparam int c_WI = (i == 0) ? 8 : (i == 1) ? 32 : (i == 2) ? 4 : 1;
      assign dif[i].in_valid  = t_iv[i];
      assign dif[i].a         = t_a;
      assign dif[i].b         = t_b;
      assign dif[i].sub       = t_sub;
      assign dif[i].cin       = t_cin;
      assign dif[i].out_ready = t_or[i];
      assign m_sum[i]  = dif[i].sum;
      assign m_ird[i]  = dif[i].in_ready;
      assign m_ovld[i] = dif[i].out_valid;
      assign m_cout[i] = dif[i].cout;
      assign m_ovf[i]  = dif[i].overflow;
      digit_serial_adder #(.N(32), .W(c_WI)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (dif[i])
      );
   end

   // Called at a negedge with the DUT idle; returns at the negedge where out_valid is seen.
   task automatic do_op(input int s, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic cin, output int lat);
      t_a = a; t_b = b; t_sub = sub; t_cin = cin; t_iv[s] = 1'b1;
      @(posedge clk); @(negedge clk);
      t_iv[s] = 1'b0;
      lat = 0;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk); @(negedge clk);
         if (m_ovld[s]) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic finish_op(input int s);
      t_or[s] = 1'b1;
      @(posedge clk); @(negedge clk);
      t_or[s] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk); @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         total++;
         if (m_ird[i] !== 1'b1 || m_ovld[i] !== 1'b0) begin
            bad++; $display("FAIL reset_hs[%0d]: in_ready=%b out_valid=%b expected 1/0", i, m_ird[i], m_ovld[i]);
         end
      end
      total++;
      if (m_sum[0] !== 32'h0 || m_cout[0] !== 1'b0 || m_ovf[0] !== 1'b0) begin
         bad++; $display("FAIL reset_outs: sum=%h cout=%b ovf=%b expected 0/0/0", m_sum[0], m_cout[0], m_ovf[0]);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_add_carry();
      int lat;
      do_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
      total++; if (lat !== 4) begin bad++; $display("FAIL add_latency: got %0d expected 4", lat); end
      total++; if (m_sum[0] !== 32'h0) begin bad++; $display("FAIL add_sum: got %h expected 00000000", m_sum[0]); end
      total++; if (m_cout[0] !== 1'b1) begin bad++; $display("FAIL add_cout: got %b expected 1", m_cout[0]); end
      total++; if (m_ovf[0] !== 1'b0) begin bad++; $display("FAIL add_ovf: got %b expected 0", m_ovf[0]); end
      finish_op(0);
      total++;
      if (m_ird[0] !== 1'b1 || m_ovld[0] !== 1'b0 || m_cout[0] !== 1'b1) begin
         bad++; $display("FAIL add_idle: in_ready=%b out_valid=%b cout=%b expected 1/0/1", m_ird[0], m_ovld[0], m_cout[0]);
      end
   endtask

   task automatic test_sub();
      int lat;
      do_op(0, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, lat);
      total++; if (m_sum[0] !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub_sum: got %h expected FFFFFFFE", m_sum[0]); end
      total++; if (m_cout[0] !== 1'b0 || m_ovf[0] !== 1'b0) begin
         bad++; $display("FAIL sub_flags: cout=%b ovf=%b expected 0/0", m_cout[0], m_ovf[0]);
      end
      finish_op(0);
      do_op(0, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, lat);
      total++; if (m_sum[0] !== 32'hFFFF_FFFD) begin bad++; $display("FAIL sub_borrow_sum: got %h expected FFFFFFFD", m_sum[0]); end
      total++; if (m_cout[0] !== 1'b0) begin bad++; $display("FAIL sub_borrow_cout: got %b expected 0", m_cout[0]); end
      finish_op(0);
   endtask

   task automatic test_overflow();
      int lat;
      do_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
      total++; if (m_sum[0] !== 32'h8000_0000) begin bad++; $display("FAIL ovf_sum: got %h expected 80000000", m_sum[0]); end
      total++; if (m_cout[0] !== 1'b0) begin bad++; $display("FAIL ovf_cout: got %b expected 0", m_cout[0]); end
      total++; if (m_ovf[0] !== c_OVF_EN) begin bad++; $display("FAIL ovf_flag: got %b expected %b", m_ovf[0], c_OVF_EN); end
      finish_op(0);
   endtask

   task automatic test_backpressure();
      int lat;
      do_op(0, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, lat);
      for (int n = 0; n < 10; n++) begin
         t_a = 32'hDEAD_BEEF; t_b = 32'h1111_1111; t_iv[0] = 1'b1;
         total++;
         if (m_ovld[0] !== 1'b1 || m_ird[0] !== 1'b0 || m_sum[0] !== 32'h0000_0030) begin
            bad++; $display("FAIL hold[%0d]: out_valid=%b in_ready=%b sum=%h expected 1/0/00000030", n, m_ovld[0], m_ird[0], m_sum[0]);
         end
         @(posedge clk); @(negedge clk);
      end
      t_iv[0] = 1'b0;
      finish_op(0);
      total++;
      if (m_ird[0] !== 1'b1 || m_ovld[0] !== 1'b0 || m_sum[0] !== 32'h0000_0030) begin
         bad++; $display("FAIL release: in_ready=%b out_valid=%b sum=%h expected 1/0/00000030", m_ird[0], m_ovld[0], m_sum[0]);
      end
   endtask

   task automatic test_reset_midrun();
      int lat;
      bit seen;
      t_a = 32'h0F0F_0F0F; t_b = 32'h0101_0101; t_sub = 1'b0; t_cin = 1'b0; t_iv[0] = 1'b1;
      @(posedge clk); @(negedge clk);
      t_iv[0] = 1'b0;
      @(posedge clk); @(posedge clk); @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if (m_ovld[0] !== 1'b0 || m_ird[0] !== 1'b1 || m_sum[0] !== 32'h0) begin
         bad++; $display("FAIL midrun_reset: out_valid=%b in_ready=%b sum=%h expected 0/1/00000000", m_ovld[0], m_ird[0], m_sum[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (m_ovld[0] === 1'b1) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrun_noresult: out_valid seen=%b expected 0", seen); end
      do_op(0, 32'h0123_4567, 32'h7654_3210, 1'b0, 1'b0, lat);
      total++;
      if (lat !== 4 || m_sum[0] !== 32'h7777_7777) begin
         bad++; $display("FAIL midrun_next: lat=%0d sum=%h expected 4/77777777", lat, m_sum[0]);
      end
      finish_op(0);
   endtask

   task automatic test_single_digit();
      int lat;
      do_op(1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, lat);
      total++;
      if (lat !== 1 || m_sum[1] !== 32'h2345_6789 || m_cout[1] !== 1'b0) begin
         bad++; $display("FAIL d1_add: lat=%0d sum=%h cout=%b expected 1/23456789/0", lat, m_sum[1], m_cout[1]);
      end
      finish_op(1);
      do_op(1, 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, lat);
      total++;
      if (lat !== 1 || m_sum[1] !== 32'hFFFF_FFFF || m_cout[1] !== 1'b0) begin
         bad++; $display("FAIL d1_sub: lat=%0d sum=%h cout=%b expected 1/FFFFFFFF/0", lat, m_sum[1], m_cout[1]);
      end
      finish_op(1);
   endtask

   task automatic test_random();
      int          lat;
      int          sel [3];
      int          dexp [3];
      logic [31:0] a, b, bb;
      logic        sub, cin, ov;
      logic [32:0] full;
      sel  = '{0, 2, 3};
      dexp = '{4, 8, 32};
      for (int j = 0; j < 3; j++) begin
         for (int n = 0; n < 150; n++) begin
            a   = $urandom;
            b   = $urandom;
            sub = 1'($urandom_range(1));
            cin = 1'($urandom_range(1));
            bb   = sub ? ~b : b;
            full = {1'b0, a} + {1'b0, bb} + {32'h0, cin ^ sub};
            ov   = c_OVF_EN & (a[31] == bb[31]) & (full[31] != a[31]);
            do_op(sel[j], a, b, sub, cin, lat);
            total++;
            if (lat !== dexp[j] || m_sum[sel[j]] !== full[31:0] || m_cout[sel[j]] !== full[32] || m_ovf[sel[j]] !== ov) begin
               bad++;
               $display("FAIL rand[u%0d,%0d]: a=%h b=%h sub=%b cin=%b got lat=%0d sum=%h c=%b v=%b expected lat=%0d sum=%h c=%b v=%b",
                        sel[j], n, a, b, sub, cin, lat, m_sum[sel[j]], m_cout[sel[j]], m_ovf[sel[j]],
                        dexp[j], full[31:0], full[32], ov);
            end
            finish_op(sel[j]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add_carry();
      test_sub();
      test_overflow();
      test_backpressure();
      test_reset_midrun();
      test_single_digit();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

`default_nettype wire
